sum_accumulator: RTL

SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

---
 rtl/sum_accumulator.sv | 72 +++++++
 1 files changed

// File: rtl/sum_accumulator.sv
// sum_accumulator: sums BLOCK_LEN 8-bit samples into a 12-bit total, emitted as two bytes (high nibble, then low byte).
// Define SUM_ACCUMULATOR_SAT_EN to clamp the total at 4095 and raise a sticky sat_flag; otherwise the total wraps.
module sum_accumulator #(
  parameter int BLOCK_LEN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       clear,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic [4:0] count,
  output logic       sat_flag
);
`ifdef SUM_ACCUMULATOR_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif
  localparam logic [4:0] LEN = 5'(BLOCK_LEN);
  typedef enum logic [1:0] {IDLE, ACCUM, EMIT_HI, EMIT_LO} state_t;
  state_t      state_q, state_d;
  logic [11:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        sat_q, sat_d;
  logic [12:0] sum;
  logic        accept;
  assign in_ready = (state_q == IDLE) || (state_q == ACCUM);
  assign accept = in_valid && in_ready;
  assign sum = {1'b0, acc_q} + {5'b0, in_data};
  assign out_valid = (state_q == EMIT_HI) || (state_q == EMIT_LO);
  assign out_last = state_q == EMIT_LO;
  assign out_data = state_q == EMIT_HI ? {4'b0, acc_q[11:8]} : state_q == EMIT_LO ? acc_q[7:0] : 8'h00;
  assign count = cnt_q;
  assign sat_flag = sat_q;
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (clear || (state_q == EMIT_LO && out_ready)) begin
      state_d = IDLE;
      acc_d = '0;
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (accept) begin
      acc_d = SAT_EN && sum[12] ? 12'hFFF : sum[11:0];
      sat_d = sat_q || (SAT_EN && sum[12]);
      cnt_d = cnt_q + 5'd1;
      state_d = cnt_d == LEN ? EMIT_HI : ACCUM;
    end else if (state_q == EMIT_HI && out_ready) begin
      state_d = EMIT_LO;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q <= '0;
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end
endmodule
